// File: rtl/adc_pack_if.sv
// adc_pack_if: FIFO-side bus of the ADC packer.
//   odata : packed word (DATA_W bits), valid while wren is high
//   wren  : one-cycle FIFO write strobe
//   sof   : start-of-frame flag, qualified by wren
//   afull : FIFO almost-full, driven by the FIFO side
// master = packer, slave = FIFO.
interface adc_pack_if #(
  parameter int DATA_W = 40
) ();
  logic [DATA_W-1:0] odata;
  logic              wren;
  logic              sof;
  logic              afull;

  modport master (output odata, output wren, output sof, input afull);
  modport slave  (input odata, input wren, input sof, output afull);
endinterface

// File: rtl/adc_pack.sv
// adc_pack: captures CH parallel ADC channels, decimates, optionally waits for
// a level crossing on channel 0, packs PACK samples per word and writes
// fixed-length frames into a FIFO. Whole words are dropped while the FIFO is
// almost full, and every dropped word is counted.
// Ports:
//   clk50, rst_n        clock and asynchronous active-low reset
//   en                  capture enable (level)
//   decim               keep 1 of every decim+1 sample ticks
//   trig_mode           0/3 free-run, 1 rising cross, 2 falling cross
//   trig_level          unsigned threshold compared on channel 0
//   frame_len           words per frame, 0 = endless
//   idata               channel c at [c*SAMPLE_W +: SAMPLE_W]
//   fifo                odata/wren/sof out, afull in
//   busy                high while armed or capturing
//   ovf_cnt             saturating dropped-word counter
module adc_pack #(
  parameter int SAMPLE_W = 10,
  parameter int CH       = 1,
  parameter int PACK     = 4,
  parameter int DECIM_W  = 8
) (
  input  logic                   clk50,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [DECIM_W-1:0]     decim,
  input  logic [1:0]             trig_mode,
  input  logic [SAMPLE_W-1:0]    trig_level,
  input  logic [15:0]            frame_len,
  input  logic [CH*SAMPLE_W-1:0] idata,
  adc_pack_if.master             fifo,
  output logic                   busy,
  output logic [15:0]            ovf_cnt
);
  localparam int WORD_W = PACK * SAMPLE_W;
  localparam int LP_W   = $clog2(PACK + 1);

  if ((PACK % CH) != 0) begin : g_bad_pack
    $error("adc_pack: PACK must be a multiple of CH");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CH*SAMPLE_W-1:0]  s1_q, s1_d;
  logic [SAMPLE_W-1:0]     s2_q, s2_d;
  logic [WORD_W-1:0]       pack_q, pack_d;
  logic [LP_W-1:0]         lane_ptr_q, lane_ptr_d;
  logic [DECIM_W-1:0]      dec_cnt_q, dec_cnt_d;
  logic [15:0]             word_cnt_q, word_cnt_d;
  logic [15:0]             frame_len_q, frame_len_d;
  logic                    sof_pend_q, sof_pend_d;
  logic [WORD_W-1:0]       odata_q, odata_d;
  logic                    wren_q, wren_d;
  logic                    sof_q, sof_d;
  logic                    busy_q, busy_d;
  logic [15:0]             ovf_cnt_q, ovf_cnt_d;

  logic                    keep;
  logic                    frame_start;
  logic                    free_run;
  logic                    trig_hit;
  logic                    sof_eff;
  logic [15:0]             frame_len_eff;

  // Advance the decimation counter: 0 is the kept tick, wraps after decim.
  function automatic logic [DECIM_W-1:0] dec_step(input logic [DECIM_W-1:0] cnt,
                                                  input logic [DECIM_W-1:0] lim);
    return (cnt >= lim) ? {DECIM_W{1'b0}} : cnt + DECIM_W'(1);
  endfunction

  // Next-state logic: trigger detection, decimation, lane packing, framing.
  always_comb begin
    state_d     = state_q;
    s1_d        = idata;
    s2_d        = s1_q[SAMPLE_W-1:0];
    pack_d      = pack_q;
    lane_ptr_d  = lane_ptr_q;
    dec_cnt_d   = dec_cnt_q;
    word_cnt_d  = word_cnt_q;
    frame_len_d = frame_len_q;
    sof_pend_d  = sof_pend_q;
    odata_d     = odata_q;
    wren_d      = 1'b0;
    sof_d       = 1'b0;
    ovf_cnt_d   = ovf_cnt_q;
    keep        = 1'b0;
    frame_start = 1'b0;
    free_run    = (trig_mode == 2'd0) || (trig_mode == 2'd3);

    case (trig_mode)
      2'd1:    trig_hit = (s2_q < trig_level) && (s1_q[SAMPLE_W-1:0] >= trig_level);
      2'd2:    trig_hit = (s2_q > trig_level) && (s1_q[SAMPLE_W-1:0] <= trig_level);
      default: trig_hit = 1'b0;
    endcase

    if (en) begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (free_run) begin
            state_d     = ST_CAPTURE;
            frame_start = 1'b1;
            dec_cnt_d   = {DECIM_W{1'b0}};
          end else if (trig_hit) begin
            // The crossing sample itself is the first kept sample.
            state_d     = ST_CAPTURE;
            frame_start = 1'b1;
            keep        = 1'b1;
            dec_cnt_d   = dec_step({DECIM_W{1'b0}}, decim);
          end else begin
            state_d = ST_ARM;
          end
        end
        ST_CAPTURE: begin
          keep      = (dec_cnt_q == {DECIM_W{1'b0}});
          dec_cnt_d = dec_step(dec_cnt_q, decim);
        end
        default: state_d = ST_IDLE;
      endcase

      // A word can complete in the trigger cycle, so framing uses the
      // values of the frame being started rather than the stale registers.
      sof_eff       = frame_start ? 1'b1 : sof_pend_q;
      frame_len_eff = frame_start ? frame_len : frame_len_q;
      if (frame_start) begin
        word_cnt_d  = 16'd0;
        frame_len_d = frame_len;
        sof_pend_d  = 1'b1;
      end else begin
        frame_len_d = frame_len_q;
      end

      if (keep) begin
        for (int c = 0; c < CH; c++) begin
          pack_d[(int'(lane_ptr_q) + c)*SAMPLE_W +: SAMPLE_W] = s1_q[c*SAMPLE_W +: SAMPLE_W];
        end
        if ((int'(lane_ptr_q) + CH) >= PACK) begin
          lane_ptr_d = {LP_W{1'b0}};
          // The frame's sof is consumed by its first word even if dropped.
          sof_pend_d = 1'b0;
          if (fifo.afull) begin
            ovf_cnt_d = (ovf_cnt_q == 16'hFFFF) ? ovf_cnt_q : ovf_cnt_q + 16'd1;
          end else begin
            odata_d = pack_d;
            wren_d  = 1'b1;
            sof_d   = sof_eff;
          end
          if ((frame_len_eff != 16'd0) && ((word_cnt_d + 16'd1) == frame_len_eff)) begin
            word_cnt_d = 16'd0;
            if (free_run) begin
              sof_pend_d  = 1'b1;
              frame_len_d = frame_len;
            end else begin
              state_d = ST_ARM;
            end
          end else begin
            word_cnt_d = word_cnt_d + 16'd1;
          end
        end else begin
          lane_ptr_d = LP_W'(int'(lane_ptr_q) + CH);
        end
      end else begin
        pack_d = pack_q;
      end
    end else begin
      // Disable abandons any partial word and the current frame.
      sof_eff       = 1'b0;
      frame_len_eff = frame_len_q;
      state_d       = ST_IDLE;
      lane_ptr_d    = {LP_W{1'b0}};
      word_cnt_d    = 16'd0;
      sof_pend_d    = 1'b0;
    end

    busy_d = (state_d == ST_ARM) || (state_d == ST_CAPTURE);
  end

  // State and output registers.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s1_q        <= '0;
      s2_q        <= '0;
      pack_q      <= '0;
      lane_ptr_q  <= '0;
      dec_cnt_q   <= '0;
      word_cnt_q  <= 16'd0;
      frame_len_q <= 16'd0;
      sof_pend_q  <= 1'b0;
      odata_q     <= '0;
      wren_q      <= 1'b0;
      sof_q       <= 1'b0;
      busy_q      <= 1'b0;
      ovf_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      pack_q      <= pack_d;
      lane_ptr_q  <= lane_ptr_d;
      dec_cnt_q   <= dec_cnt_d;
      word_cnt_q  <= word_cnt_d;
      frame_len_q <= frame_len_d;
      sof_pend_q  <= sof_pend_d;
      odata_q     <= odata_d;
      wren_q      <= wren_d;
      sof_q       <= sof_d;
      busy_q      <= busy_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign fifo.odata = odata_q;
  assign fifo.wren  = wren_q;
  assign fifo.sof   = sof_q;
  assign busy       = busy_q;
  assign ovf_cnt    = ovf_cnt_q;
endmodule

// File: tb/tb_adc_pack.sv
// tb_adc_pack: scoreboard bench for adc_pack. dut1 is CH=1/PACK=4, dut2 is
// CH=2/PACK=4. Expected words are queued before stimulus; monitors on the
// falling edge pop and compare whenever wren is high.
module tb_adc_pack;
  logic        clk50 = 1'b0;
  logic        rst_n;
  logic        en1, en2;
  logic [7:0]  decim;
  logic [1:0]  trig_mode;
  logic [9:0]  trig_level;
  logic [15:0] frame_len;
  logic [9:0]  idata1;
  logic [19:0] idata2;
  logic        busy1, busy2;
  logic [15:0] ovf1, ovf2;

  typedef struct packed {
    logic [39:0] d;
    logic        s;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   wc1[$];
  int   wc2[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0;

  adc_pack_if #(.DATA_W(40)) bus1 ();
  adc_pack_if #(.DATA_W(40)) bus2 ();

  adc_pack #(.SAMPLE_W(10), .CH(1), .PACK(4), .DECIM_W(8)) dut1 (
    .clk50(clk50), .rst_n(rst_n), .en(en1), .decim(decim), .trig_mode(trig_mode),
    .trig_level(trig_level), .frame_len(frame_len), .idata(idata1), .fifo(bus1),
    .busy(busy1), .ovf_cnt(ovf1)
  );

  adc_pack #(.SAMPLE_W(10), .CH(2), .PACK(4), .DECIM_W(8)) dut2 (
    .clk50(clk50), .rst_n(rst_n), .en(en2), .decim(decim), .trig_mode(trig_mode),
    .trig_level(trig_level), .frame_len(frame_len), .idata(idata2), .fifo(bus2),
    .busy(busy2), .ovf_cnt(ovf2)
  );

  always #5 clk50 = ~clk50;

  always @(posedge clk50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Lane 0 is the earliest sample and sits in the LSBs.
  function automatic logic [39:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {10'(l3), 10'(l2), 10'(l1), 10'(l0)};
  endfunction

  // Triangle "sine": period 32, rising 0x100..0x2E0, falling 0x300..0x120.
  function automatic int wave(input int n);
    int m;
    m = n % 32;
    return (m < 16) ? (256 + 32*m) : (768 - 32*(m - 16));
  endfunction

  function automatic exp_t mk(input logic [39:0] d, input logic s);
    exp_t e;
    e.d = d;
    e.s = s;
    return e;
  endfunction

  // Monitor for dut1.
  always @(negedge clk50) begin
    if (bus1.wren === 1'b1) begin
      wc1.push_back(cyc);
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected word: got 0x%0h sof %0b, none required", bus1.odata, bus1.sof);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1 odata", bus1.odata, e.d);
        chk("dut1 sof", bus1.sof, e.s);
      end
    end
  end

  // Monitor for dut2.
  always @(negedge clk50) begin
    if (bus2.wren === 1'b1) begin
      wc2.push_back(cyc);
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut2 unexpected word: got 0x%0h sof %0b, none required", bus2.odata, bus2.sof);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2 odata", bus2.odata, e.d);
        chk("dut2 sof", bus2.sof, e.s);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Ramp on dut1: base in the first two cycles, then base+k; afull high so
  // that it is sampled on the edge where the afull_k-th ramp step is seen.
  task automatic ramp(input int base, input int last_k, input int afull_k, output int t0);
    en1 = 1'b1;
    idata1 = 10'(base);
    t0 = cyc;
    tick(1);
    idata1 = 10'(base);
    for (int k = 1; k <= last_k; k++) begin
      tick(1);
      idata1 = 10'(base + k);
      bus1.afull = (k == afull_k);
    end
    bus1.afull = 1'b0;
    en1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en1 = 1'b0; en2 = 1'b0;
    decim = 8'd0; trig_mode = 2'd0; trig_level = 10'd0; frame_len = 16'd0;
    idata1 = 10'd0; idata2 = 20'd0;
    bus1.afull = 1'b0; bus2.afull = 1'b0;
    #12;
    chk("reset odata", bus1.odata, 64'd0);
    chk("reset wren", bus1.wren, 64'd0);
    chk("reset sof", bus1.sof, 64'd0);
    chk("reset busy", busy1, 64'd0);
    chk("reset ovf_cnt", ovf1, 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Free-run ramp, frame of 2 words.
    frame_len = 16'd2;
    q1.push_back(mk(pk(0, 1, 2, 3), 1'b1));
    q1.push_back(mk(pk(4, 5, 6, 7), 1'b0));
    q1.push_back(mk(pk(8, 9, 10, 11), 1'b1));
    q1.push_back(mk(pk(12, 13, 14, 15), 1'b0));
    wc1.delete();
    ramp(0, 18, -1, c0);
    tick(1);
    chk("freerun latency", wc1[0] - c0, 64'd6);
    chk("freerun words", wc1.size(), 64'd4);
    chk("busy after disable", busy1, 64'd0);

    // Decimation by 3, endless frame.
    do_reset();
    decim = 8'd2; frame_len = 16'd0;
    q1.push_back(mk(pk(0, 3, 6, 9), 1'b1));
    q1.push_back(mk(pk(12, 15, 18, 21), 1'b0));
    wc1.delete();
    ramp(0, 25, -1, c0);
    tick(2);
    chk("decim first word", wc1[0] - c0, 64'd12);
    chk("decim wren period", wc1[1] - wc1[0], 64'd12);

    // Rising trigger at 0x200, 4-word frames, re-arm between crossings.
    do_reset();
    decim = 8'd0; trig_mode = 2'd1; trig_level = 10'h200; frame_len = 16'd4;
    for (int w = 0; w < 4; w++) begin
      q1.push_back(mk(pk(wave(8+4*w), wave(9+4*w), wave(10+4*w), wave(11+4*w)), (w == 0)));
    end
    for (int w = 0; w < 4; w++) begin
      q1.push_back(mk(pk(wave(40+4*w), wave(41+4*w), wave(42+4*w), wave(43+4*w)), (w == 0)));
    end
    wc1.delete();
    en1 = 1'b1;
    idata1 = 10'(wave(0));
    c0 = cyc;
    for (int n = 1; n <= 58; n++) begin
      tick(1);
      idata1 = 10'(wave(n));
      if (n == 30) chk("busy while rearmed", busy1, 64'd1);
    end
    en1 = 1'b0;
    tick(2);
    chk("trig first word", wc1[0] - c0, 64'd13);
    chk("trig rearm gap", wc1[4] - wc1[3], 64'd20);
    trig_mode = 2'd0;

    // One dropped word mid-frame.
    do_reset();
    frame_len = 16'd4;
    q1.push_back(mk(pk(0, 1, 2, 3), 1'b1));
    q1.push_back(mk(pk(8, 9, 10, 11), 1'b0));
    q1.push_back(mk(pk(12, 13, 14, 15), 1'b0));
    q1.push_back(mk(pk(16, 17, 18, 19), 1'b1));
    ramp(0, 21, 8, c0);
    tick(3);
    chk("ovf_cnt after drop", ovf1, 64'd1);

    // Asynchronous reset with two lanes filled.
    en1 = 1'b1; idata1 = 10'd0;
    tick(1); idata1 = 10'd0;
    tick(1); idata1 = 10'd1;
    tick(1); idata1 = 10'd2;
    tick(1);
    chk("busy mid-word", busy1, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst odata", bus1.odata, 64'd0);
    chk("async rst wren", bus1.wren, 64'd0);
    chk("async rst sof", bus1.sof, 64'd0);
    chk("async rst busy", busy1, 64'd0);
    chk("async rst ovf_cnt", ovf1, 64'd0);
    en1 = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Disable with two lanes filled, then re-enable.
    en1 = 1'b1; idata1 = 10'd0;
    tick(1); idata1 = 10'd0;
    tick(1); idata1 = 10'd1;
    tick(1); idata1 = 10'd2;
    tick(1);
    en1 = 1'b0;
    tick(3);
    chk("busy after mid-word disable", busy1, 64'd0);
    q1.push_back(mk(pk(100, 101, 102, 103), 1'b1));
    q1.push_back(mk(pk(104, 105, 106, 107), 1'b0));
    ramp(100, 9, -1, c0);
    tick(3);

    // Two channels, four lanes.
    frame_len = 16'd0;
    for (int w = 0; w < 3; w++) q2.push_back(mk(pk(17, 34, 17, 34), (w == 0)));
    wc2.delete();
    en2 = 1'b1;
    idata2 = {10'h022, 10'h011};
    c0 = cyc;
    tick(8);
    en2 = 1'b0;
    tick(3);
    chk("ch2 first word", wc2[0] - c0, 64'd4);
    chk("ch2 word period", wc2[1] - wc2[0], 64'd2);
    chk("ch2 words", wc2.size(), 64'd3);

    chk("dut1 words outstanding", q1.size(), 64'd0);
    chk("dut2 words outstanding", q2.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
